sobel_window_sched: RTL and testbench

- Scheduler that sequences the 3x3 Sobel window datapath between the grayscale FIFO (8-bit, first-word-fall-through) and the output FIFO.
- Decides each cycle whether to pop an input pixel, shift the line buffers or window, inject zero padding, and write an output pixel.
- Tracks the window-center row and column, and flags border pixels so the datapath writes 0 there.
- Produces exactly WIDTH*HEIGHT outputs per frame, in raster order.

---
 rtl/sobel_window_sched_if.sv | 32 +++
 rtl/sobel_window_sched.sv | 116 +++++++++++
 tb/tb_sobel_window_sched.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_sched_if.sv
// Handshake and status bundle between the Sobel window scheduler and its
// surroundings: grayscale FIFO flags, output FIFO flags, datapath strobes.
interface sobel_window_sched_if #(
  parameter int ROW_W = 10,
  parameter int COL_W = 10
);
  logic             start;
  logic             in_empty;
  logic             in_rd_en;
  logic             out_full;
  logic             out_wr_en;
  logic             shift_en;
  logic             shift_zero;
  logic             border;
  logic [ROW_W-1:0] center_row;
  logic [COL_W-1:0] center_col;
  logic             busy;
  logic             frame_done;
  logic [31:0]      stall_cycles;

  modport master (
    input  start, in_empty, out_full,
    output in_rd_en, out_wr_en, shift_en, shift_zero, border,
           center_row, center_col, busy, frame_done, stall_cycles
  );

  modport slave (
    output start, in_empty, out_full,
    input  in_rd_en, out_wr_en, shift_en, shift_zero, border,
           center_row, center_col, busy, frame_done, stall_cycles
  );
endinterface

// File: rtl/sobel_window_sched.sv
// Sequences the 3x3 Sobel window: pop/shift/zero-pad/write per cycle, raster output.
// Optional stall counter enabled by defining SOBEL_WINDOW_SCHED_STALL_CNT_EN.
module sobel_window_sched #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  sobel_window_sched_if.master  bus
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] in_cnt;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             adv, rd, wr, sh, sz, accept, last_pos;

  assign accept   = (state == IDLE) && bus.start;
  assign last_pos = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    state_n = state;
    adv     = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    sh      = 1'b0;
    sz      = 1'b0;
    case (state)
      IDLE: if (bus.start) state_n = FILL;
      FILL: begin
        adv = !bus.in_empty;
        rd  = adv;
        sh  = adv;
        if (adv && in_cnt == FILL_LAST) state_n = RUN;
      end
      RUN: begin
        // both FIFOs must be ready, otherwise nothing moves at all
        adv = !bus.in_empty && !bus.out_full;
        rd  = adv;
        sh  = adv;
        wr  = adv;
        if (adv && in_cnt == RUN_LAST) state_n = DRAIN;
      end
      DRAIN: begin
        adv = !bus.out_full;
        sh  = adv;
        sz  = adv;
        wr  = adv;
        if (adv && last_pos) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      in_cnt <= '0;
      row    <= '0;
      col    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        in_cnt <= '0;
        row    <= '0;
        col    <= '0;
      end else begin
        if (rd) in_cnt <= in_cnt + 1'b1;
        if (wr) begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

`ifdef SOBEL_WINDOW_SCHED_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stalled;
  assign stalled = (state == FILL || state == RUN || state == DRAIN) && !adv;

  always_ff @(posedge clock) begin
    if (reset)                                    stall_q <= '0;
    else if (accept)                              stall_q <= '0;
    else if (stalled && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 1'b1;
  end
  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = '0;
`endif

  assign bus.in_rd_en   = rd;
  assign bus.out_wr_en  = wr;
  assign bus.shift_en   = sh;
  assign bus.shift_zero = sz;
  assign bus.center_row = row;
  assign bus.center_col = col;
  assign bus.border     = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == DONE);
endmodule

// File: tb/tb_sobel_window_sched.sv
// Directed bench: 4x3 frames under clean/stalled/toggled flow plus mid-frame
// reset, and a 40x25 frame with start pulses while busy.
module tb_sobel_window_sched;
  logic clock, reset;
  int   nvec, nerr, cyc;

  sobel_window_sched_if ia();
  sobel_window_sched_if ib();

  sobel_window_sched #(.WIDTH(4), .HEIGHT(3), .COL_W(10), .ROW_W(10))
    u_a (.clock(clock), .reset(reset), .bus(ia.master));
  sobel_window_sched #(.WIDTH(40), .HEIGHT(25), .COL_W(10), .ROW_W(10))
    u_b (.clock(clock), .reset(reset), .bus(ib.master));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // monitor state for DUT A
  int   pops, writes, fill_pops, first_wr_pop, fd_cnt, stall_seen, viol;
  int   last_wr_cyc, fd_cyc, busy_fall_cyc;
  logic busy_d;
  logic [19:0] posq[$];
  bit   zq[$], bq[$];
  // monitor state for DUT B
  int   pops_b, writes_b, fd_b;
  logic [19:0] last_b;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (ia.in_rd_en) pops++;
      if (ia.in_rd_en && !ia.out_wr_en) fill_pops++;
      if (ia.out_wr_en) begin
        writes++;
        if (writes == 1) first_wr_pop = pops;
        posq.push_back({ia.center_row, ia.center_col});
        zq.push_back(ia.shift_zero);
        bq.push_back(ia.border);
        last_wr_cyc = cyc;
      end
      if (ia.frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (busy_d && !ia.busy) busy_fall_cyc = cyc;
      if (ia.busy && !ia.frame_done && !ia.shift_en) stall_seen++;
      if (ia.in_empty && ia.in_rd_en) viol++;
      if (ia.out_full && ia.out_wr_en) viol++;
      if (ia.out_full && writes > 0 && (ia.in_rd_en || ia.shift_en)) viol++;
      busy_d = ia.busy;
      if (ib.in_rd_en) pops_b++;
      if (ib.out_wr_en) begin
        writes_b++;
        last_b = {ib.center_row, ib.center_col};
      end
      if (ib.frame_done) fd_b++;
    end
  end

  task automatic clr_mon();
    pops = 0; writes = 0; fill_pops = 0; first_wr_pop = 0; fd_cnt = 0;
    stall_seen = 0; viol = 0; last_wr_cyc = 0; fd_cyc = 0; busy_fall_cyc = 0;
    posq.delete(); zq.delete(); bq.delete();
  endtask

  // mode 0 clean, 1 out_full burst mid-RUN, 2 in_empty toggle + random out_full
  task automatic frame_a(input int mode);
    int hold;
    bit done;
    hold = 0;
    done = 1'b0;
    clr_mon();
    ia.start = 1'b1;
    @(posedge clock); #1;
    ia.start = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (fd_cnt > 0 && !ia.busy) begin
        done = 1'b1;
        break;
      end
      case (mode)
        1: if (writes >= 2 && hold < 3) begin
             ia.out_full = 1'b1;
             hold++;
           end else ia.out_full = 1'b0;
        2: begin
             ia.in_empty = ~ia.in_empty;
             ia.out_full = 1'($urandom_range(0, 1));
           end
        default: ;
      endcase
      @(posedge clock); #1;
    end
    ia.in_empty = 1'b0;
    ia.out_full = 1'b0;
    chk("frame_timeout", 32'(done), 1);
    @(negedge clock); #1;
  endtask

  task automatic check_frame(input string tag, input int exp_stall);
    chk({tag, "_pops"}, pops, 12);
    chk({tag, "_writes"}, writes, 12);
    chk({tag, "_fill_pops"}, fill_pops, 5);
    chk({tag, "_first_wr_pop"}, first_wr_pop, 6);
    chk({tag, "_frame_done_cnt"}, fd_cnt, 1);
    chk({tag, "_fd_after_last_wr"}, fd_cyc - last_wr_cyc, 1);
    chk({tag, "_busy_fall"}, busy_fall_cyc - fd_cyc, 1);
    chk({tag, "_viol"}, viol, 0);
    chk({tag, "_stall_cycles"}, ia.stall_cycles, 32'(exp_stall));
    for (int i = 0; i < 12 && i < posq.size(); i++) begin
      int r, c;
      r = i / 4;
      c = i % 4;
      chk($sformatf("%s_pos%0d", tag, i), 32'(posq[i]), 32'((r << 10) | c));
      chk($sformatf("%s_border%0d", tag, i), 32'(bq[i]),
          32'((r == 0 || r == 2 || c == 0 || c == 3) ? 1 : 0));
      chk($sformatf("%s_zero%0d", tag, i), 32'(zq[i]), 32'((i >= 7) ? 1 : 0));
    end
  endtask

  initial begin
    bit done_b;
    nvec = 0; nerr = 0; cyc = 0; busy_d = 1'b0;
    pops_b = 0; writes_b = 0; fd_b = 0; last_b = '0;
    clr_mon();
    reset = 1'b1;
    ia.start = 1'b0; ia.in_empty = 1'b0; ia.out_full = 1'b0;
    ib.start = 1'b0; ib.in_empty = 1'b0; ib.out_full = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", ia.busy, 0);
    chk("rst_frame_done", ia.frame_done, 0);
    chk("rst_row", 32'(ia.center_row), 0);
    chk("rst_col", 32'(ia.center_col), 0);
    chk("rst_stall", ia.stall_cycles, 0);
    chk("rst_rd", ia.in_rd_en, 0);
    chk("rst_wr", ia.out_wr_en, 0);
    chk("rst_shift", ia.shift_en, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    frame_a(0);
    check_frame("clean", 0);

    frame_a(1);
    chk("burst_stall_seen", stall_seen, 3);
`ifdef SOBEL_WINDOW_SCHED_STALL_CNT_EN
    check_frame("burst", 3);
`else
    check_frame("burst", 0);
`endif

    frame_a(2);
`ifdef SOBEL_WINDOW_SCHED_STALL_CNT_EN
    check_frame("toggle", stall_seen);
`else
    check_frame("toggle", 0);
`endif

    // abandon a frame after its third write
    clr_mon();
    ia.start = 1'b1;
    @(posedge clock); #1;
    ia.start = 1'b0;
    for (int t = 0; t < 50 && writes < 3; t++) begin
      @(posedge clock); #1;
    end
    chk("midrst_reached_wr3", writes, 3);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_busy", ia.busy, 0);
    chk("midrst_row", 32'(ia.center_row), 0);
    chk("midrst_col", 32'(ia.center_col), 0);
    chk("midrst_wr", ia.out_wr_en, 0);
    chk("midrst_shift", ia.shift_en, 0);
    @(posedge clock); #1;
    frame_a(0);
    check_frame("after_rst", 0);

    // larger frame, start pulsed while busy must be ignored
    pops_b = 0; writes_b = 0; fd_b = 0;
    done_b = 1'b0;
    ib.start = 1'b1;
    @(posedge clock); #1;
    ib.start = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (fd_b > 0 && !ib.busy) begin
        done_b = 1'b1;
        break;
      end
      ib.start = (t == 10 || t == 500 || t == 990) ? 1'b1 : 1'b0;
      @(posedge clock); #1;
    end
    ib.start = 1'b0;
    chk("big_timeout", 32'(done_b), 1);
    repeat (5) @(posedge clock);
    #1;
    chk("big_idle_after", ib.busy, 0);
    chk("big_pops", pops_b, 1000);
    chk("big_writes", writes_b, 1000);
    chk("big_frame_done", fd_b, 1);
    chk("big_last_pos", 32'(last_b), 32'((24 << 10) | 39));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
